stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
Executes Forth stack primitives on the data stack. Caches the top two entries (TOS, NOS) in registers and spills deeper entries to, or refills them from, an external push/pop stack memory. Accepts one opcode at a time through a valid/ready handshake and sequences the memory push/pop traffic the opcode needs. Sits between the instruction decoder and the stack RAM.

Parameters:
DATA_WIDTH, 16, width of a stack cell.
ADDR_WIDTH, 10, external stack memory holds 2**ADDR_WIDTH cells. Total capacity is 2**ADDR_WIDTH+2.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high.
cmd_valid  input  1  opcode present.
cmd_ready  output  1  sequencer can accept an opcode this cycle.
cmd_op  input  3  opcode (encodings in package).
cmd_data  input  DATA_WIDTH  literal for LIT.
tos  output  DATA_WIDTH  cached top of stack.
nos  output  DATA_WIDTH  cached next of stack.
depth  output  ADDR_WIDTH+1  total entries (cache + memory).
empty  output  1  depth==0.
err_underflow  output  1  sticky: an opcode needed more entries than present.
err_overflow  output  1  sticky: a push was attempted at full capacity.
mem_push  output  1  write mem_wdata onto the memory stack this cycle.
mem_wdata  output  DATA_WIDTH  spill data.
mem_pop  output  1  pop the memory stack this cycle.
mem_rdata  input  DATA_WIDTH  popped cell, valid the cycle after mem_pop.

Behaviour:
- Reset: tos=0, nos=0, depth=0, empty=1, err flags=0, state IDLE, cmd_ready=1, mem_push=0, mem_pop=0. Reset dominates every other event, including a pending FILL. The memory shares reset and empties concurrently.
- Invariant: cache holds min(depth,2) entries; memory holds max(depth-2,0) entries.
- FSM states:
  - IDLE: cmd_ready=1.
  - FILL: cmd_ready=0; lasts exactly 1 cycle, then returns to IDLE.
- Accept: cmd_valid and cmd_ready both high at a rising edge. mem_push and mem_pop are combinational from acceptance and are never both high in the same cycle.
- Opcodes (stack shown as ( a b ), b=TOS):
  - NOP=0: no change.
  - LIT=1: push cmd_data.
  - DUP=3: push tos; needs depth>=1.
  - OVER=5: push nos; needs depth>=2.
  - DROP=2: needs depth>=1.
  - SWAP=4: exchange tos and nos; needs depth>=2; 1 cycle.
  - ADD=6: tos<=nos+tos; needs depth>=2.
  - SUB=7: tos<=nos-tos; needs depth>=2.
- Arithmetic is modulo 2**DATA_WIDTH; no carry or flags.
- Push: if depth>=2, mem_push=1 with mem_wdata=nos, then nos<=tos. The new value goes to tos. depth+1. Single cycle; cmd_ready stays 1.
- Pop (DROP/ADD/SUB):
  - tos <= nos (or the ALU result for ADD/SUB).
  - depth-1.
  - If depth>2 at acceptance: mem_pop=1 in the acceptance cycle, go to FILL, capture nos<=mem_rdata at the end of FILL, and cmd_ready returns to 1 in the next cycle.
  - Otherwise single cycle, and vacated cache slots read 0.
- Error (insufficient depth, or a push with depth==2**ADDR_WIDTH+2): the opcode is still accepted (handshake completes), but stack, depth and memory are unchanged. The matching sticky flag sets. Only reset clears the flags.
- cmd_valid while in FILL is not accepted. The driver must hold it stable until accepted.

Optional Feature:
STACK_HIGH_WATER_EN.
- Defined: adds output high_water (ADDR_WIDTH+1), the maximum depth reached since reset. Reset value 0. Updates on the same edge as depth.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package stack_pkg:
  - opcode enum (3 bits, values above).
  - FSM state enum {IDLE, FILL}.
  - DATA_WIDTH/ADDR_WIDTH defaults.
- Natural sub-module: stack_alu (combinational ADD/SUB on nos/tos). The FSM, cache and depth counter stay in stack_sequencer.

Test Plan:
- Reset, then LIT 5, LIT 7, ADD -> tos=12, depth=1, no mem_push/mem_pop, cmd_ready never drops.
- LIT 1,2,3 -> third LIT asserts mem_push with mem_wdata=1; tos=3, nos=2, depth=3. Then DROP -> mem_pop same cycle, cmd_ready=0 one cycle, nos=1 (memory model returns 1), tos=2, depth=2.
- Empty stack: DROP then SWAP -> both accepted, err_underflow=1, depth stays 0. Flag persists until reset.
- ADDR_WIDTH=2: 6 LITs reach depth=6; a 7th LIT -> err_overflow=1, depth=6, no mem_push.
- LIT 0xFFFF, LIT 1, ADD -> tos=0x0000 (wrap). LIT 3, LIT 5, SUB -> tos=0xFFFE.
- Depth 4, issue SUB, assert reset in the FILL cycle -> next cycle depth=0, tos=nos=0, cmd_ready=1, flags=0. With STACK_HIGH_WATER_EN, high_water=0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types for the Forth data-stack sequencer: opcodes, FSM states, default widths.
package stack_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LIT  = 3'd1,
        OP_DROP = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_OVER = 3'd5,
        OP_ADD  = 3'd6,
        OP_SUB  = 3'd7
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    function automatic logic op_is_push(input opcode_e op);
        return (op == OP_LIT) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

    function automatic logic op_is_pop(input opcode_e op);
        return (op == OP_DROP) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ADD/SUB on the cached stack pair: result = nos +/- tos, modulo 2**DATA_WIDTH.
// Latency: none. Backpressure: none (pure logic).
module stack_alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] nos,
    input  logic [DATA_WIDTH-1:0] tos,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = sub ? (nos - tos) : (nos + tos);
    end

endmodule

// File: rtl/stack_sequencer.sv
// Forth data-stack sequencer: TOS/NOS cached in flops, deeper cells spilled to/refilled from an external stack RAM.
// Latency: 1 cycle per opcode; pops that need a refill take one extra FILL cycle with cmd_ready low.
// Backpressure: cmd_ready drops only during FILL. Optional STACK_HIGH_WATER_EN adds a high_water output.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [DATA_WIDTH-1:0] nos,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  empty,
    output logic                  err_underflow,
    output logic                  err_overflow,
    output logic                  mem_push,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_pop,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef STACK_HIGH_WATER_EN
    ,
    output logic [ADDR_WIDTH:0]   high_water
`endif
);

    localparam int DW = ADDR_WIDTH + 1;
    localparam logic [DW-1:0] ONE      = DW'(1);
    localparam logic [DW-1:0] TWO      = DW'(2);
    localparam logic [DW-1:0] CAPACITY = DW'((2 ** ADDR_WIDTH) + 2);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tos_q, tos_d;
    logic [DATA_WIDTH-1:0] nos_q, nos_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic                  err_uf_q, err_uf_d;
    logic                  err_of_q, err_of_d;

    opcode_e               op;
    logic                  accept;
    logic [DW-1:0]         need;
    logic                  underflow;
    logic                  overflow;
    logic                  exec;
    logic [DATA_WIDTH-1:0] push_val;
    logic [DATA_WIDTH-1:0] alu_res;

    assign op        = opcode_e'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    stack_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .nos    (nos_q),
        .tos    (tos_q),
        .sub    (op == OP_SUB),
        .result (alu_res)
    );

    always_comb begin
        need = '0;
        case (op)
            OP_DUP, OP_DROP:                   need = ONE;
            OP_OVER, OP_SWAP, OP_ADD, OP_SUB: need = TWO;
            default:                           need = '0;
        endcase
    end

    // Underflow wins over overflow; they cannot coincide since a full stack satisfies any depth need.
    assign underflow = accept && (depth_q < need);
    assign overflow  = accept && !underflow && op_is_push(op) && (depth_q == CAPACITY);
    assign exec      = accept && !underflow && !overflow;

    always_comb begin
        push_val = cmd_data;
        case (op)
            OP_DUP:  push_val = tos_q;
            OP_OVER: push_val = nos_q;
            default: push_val = cmd_data;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tos_d     = tos_q;
        nos_d     = nos_q;
        depth_d   = depth_q;
        err_uf_d  = err_uf_q | underflow;
        err_of_d  = err_of_q | overflow;
        mem_push  = 1'b0;
        mem_pop   = 1'b0;
        mem_wdata = nos_q;

        if (state_q == ST_FILL) begin
            nos_d   = mem_rdata;
            state_d = ST_IDLE;
        end else if (exec) begin
            if (op_is_push(op)) begin
                mem_push = (depth_q >= TWO);
                nos_d    = tos_q;
                tos_d    = push_val;
                depth_d  = depth_q + ONE;
            end else if (op == OP_SWAP) begin
                tos_d = nos_q;
                nos_d = tos_q;
            end else if (op_is_pop(op)) begin
                tos_d   = (op == OP_DROP) ? nos_q : alu_res;
                depth_d = depth_q - ONE;
                if (depth_q > TWO) begin
                    mem_pop = 1'b1;
                    state_d = ST_FILL;
                end else begin
                    nos_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tos_q    <= '0;
            nos_q    <= '0;
            depth_q  <= '0;
            err_uf_q <= 1'b0;
            err_of_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tos_q    <= tos_d;
            nos_q    <= nos_d;
            depth_q  <= depth_d;
            err_uf_q <= err_uf_d;
            err_of_q <= err_of_d;
        end
    end

    assign tos           = tos_q;
    assign nos           = nos_q;
    assign depth         = depth_q;
    assign empty         = (depth_q == '0);
    assign err_underflow = err_uf_q;
    assign err_overflow  = err_of_q;

`ifdef STACK_HIGH_WATER_EN
    logic [DW-1:0] high_water_q, high_water_d;

    always_comb begin
        high_water_d = (depth_d > high_water_q) ? depth_d : high_water_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            high_water_q <= '0;
        end else begin
            high_water_q <= high_water_d;
        end
    end

    assign high_water = high_water_q;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer (ADDR_WIDTH=2, capacity 6) against a whole-stack queue model.
module tb_stack_sequencer;
    import stack_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 2;
    localparam int CAP = (1 << AW) + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] tos, nos;
    logic [AW:0]   depth;
    logic          empty, err_underflow, err_overflow;
    logic          mem_push, mem_pop;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef STACK_HIGH_WATER_EN
    logic [AW:0]   high_water;
`endif

    stack_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .tos           (tos),
        .nos           (nos),
        .depth         (depth),
        .empty         (empty),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .mem_push      (mem_push),
        .mem_wdata     (mem_wdata),
        .mem_pop       (mem_pop),
        .mem_rdata     (mem_rdata)
`ifdef STACK_HIGH_WATER_EN
        ,
        .high_water    (high_water)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // External stack RAM: LIFO queue, read data registered one cycle after pop.
    logic [DW-1:0] mem_q[$];
    always @(posedge clock) begin
        if (reset) begin
            mem_q.delete();
        end else if (mem_push) begin
            chk("mem_not_full", 32'(mem_q.size() < (1 << AW)), 1);
            mem_q.push_back(mem_wdata);
        end else if (mem_pop) begin
            chk("mem_not_empty", 32'(mem_q.size() > 0), 1);
            if (mem_q.size() > 0) mem_rdata <= mem_q.pop_back();
        end
    end

    typedef struct {
        logic          exp_push;
        logic          exp_pop;
        logic [DW-1:0] exp_wdata;
        logic [DW-1:0] exp_tos;
        logic [DW-1:0] exp_nos;
        int            exp_depth;
        logic          exp_uf;
        logic          exp_of;
        int            exp_hw;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_stk[$];
    logic          ref_uf = 1'b0;
    logic          ref_of = 1'b0;
    int            ref_hw = 0;

    task automatic model_cmd(input logic [2:0] op, input logic [DW-1:0] d);
        exp_t          e;
        int            n;
        int            need;
        logic          is_push;
        logic [DW-1:0] a, b, r;
        n           = ref_stk.size();
        e.exp_tos   = (n >= 1) ? ref_stk[n-1] : '0;
        e.exp_nos   = (n >= 2) ? ref_stk[n-2] : '0;
        e.exp_depth = n;
        e.exp_uf    = ref_uf;
        e.exp_of    = ref_of;
        e.exp_hw    = ref_hw;
        e.exp_push  = 1'b0;
        e.exp_pop   = 1'b0;
        e.exp_wdata = '0;
        case (op)
            3'd2, 3'd3:             need = 1;
            3'd4, 3'd5, 3'd6, 3'd7: need = 2;
            default:                need = 0;
        endcase
        is_push = (op == 3'd1) || (op == 3'd3) || (op == 3'd5);
        if (n < need) begin
            ref_uf = 1'b1;
        end else if (is_push && n == CAP) begin
            ref_of = 1'b1;
        end else begin
            case (op)
                3'd1, 3'd3, 3'd5: begin
                    r = (op == 3'd1) ? d : (op == 3'd3) ? e.exp_tos : e.exp_nos;
                    if (n >= 2) begin
                        e.exp_push  = 1'b1;
                        e.exp_wdata = e.exp_nos;
                    end
                    ref_stk.push_back(r);
                end
                3'd4: begin
                    ref_stk[n-1] = e.exp_nos;
                    ref_stk[n-2] = e.exp_tos;
                end
                3'd2: begin
                    void'(ref_stk.pop_back());
                    e.exp_pop = (n > 2);
                end
                3'd6, 3'd7: begin
                    b = ref_stk.pop_back();
                    a = ref_stk.pop_back();
                    r = (op == 3'd6) ? a + b : a - b;
                    ref_stk.push_back(r);
                    e.exp_pop = (n > 2);
                end
                default: ;
            endcase
        end
        if (ref_stk.size() > ref_hw) ref_hw = ref_stk.size();
        sb.push_back(e);
    endtask

    // Monitor: on each handshake compare pre-op state and memory strobes, then the ready level after the edge.
    exp_t e_mon;
    int   pend = 0;
    always @(negedge clock) begin
        if (reset) begin
            pend = 0;
        end else begin
            if (pend != 0) begin
                chk("ready_after_accept", 32'(cmd_ready), 32'(pend == 1));
                pend = 0;
            end
            if (cmd_valid && cmd_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_has_entry", 32'(sb.size()), 1);
                end else begin
                    e_mon = sb.pop_front();
                    chk("tos", 32'(tos), 32'(e_mon.exp_tos));
                    chk("nos", 32'(nos), 32'(e_mon.exp_nos));
                    chk("depth", 32'(depth), 32'(e_mon.exp_depth));
                    chk("empty", 32'(empty), 32'(e_mon.exp_depth == 0));
                    chk("err_underflow", 32'(err_underflow), 32'(e_mon.exp_uf));
                    chk("err_overflow", 32'(err_overflow), 32'(e_mon.exp_of));
                    chk("mem_push", 32'(mem_push), 32'(e_mon.exp_push));
                    chk("mem_pop", 32'(mem_pop), 32'(e_mon.exp_pop));
                    if (e_mon.exp_push) chk("mem_wdata", 32'(mem_wdata), 32'(e_mon.exp_wdata));
`ifdef STACK_HIGH_WATER_EN
                    chk("high_water", 32'(high_water), 32'(e_mon.exp_hw));
`endif
                    pend = e_mon.exp_pop ? 2 : 1;
                end
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic issue(input logic [2:0] op, input logic [DW-1:0] d);
        int n;
        model_cmd(op, d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 1);
            void'(sb.pop_back());
        end else begin
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic clear_model();
        ref_stk.delete();
        ref_uf = 1'b0;
        ref_of = 1'b0;
        ref_hw = 0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        clear_model();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tos"}, 32'(tos), 0);
        chk({tag, "_nos"}, 32'(nos), 0);
        chk({tag, "_depth"}, 32'(depth), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_err_underflow"}, 32'(err_underflow), 0);
        chk({tag, "_err_overflow"}, 32'(err_overflow), 0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_mem_push"}, 32'(mem_push), 0);
        chk({tag, "_mem_pop"}, 32'(mem_pop), 0);
`ifdef STACK_HIGH_WATER_EN
        chk({tag, "_high_water"}, 32'(high_water), 0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]    rop;
        logic [DW-1:0] rdat;
        do_reset();
        check_reset_state("reset");

        issue(3'd1, 16'd5); issue(3'd1, 16'd7); issue(3'd6, 16'd0); issue(3'd0, 16'd0);

        do_reset();
        issue(3'd1, 16'd1); issue(3'd1, 16'd2); issue(3'd1, 16'd3);
        issue(3'd2, 16'd0); issue(3'd0, 16'd0);

        do_reset();
        issue(3'd2, 16'd0); issue(3'd4, 16'd0); issue(3'd0, 16'd0);
        issue(3'd1, 16'd9); issue(3'd0, 16'd0);
        do_reset();
        check_reset_state("flags_cleared");

        for (int i = 0; i < 7; i++) issue(3'd1, 16'(i + 10));
        issue(3'd0, 16'd0);

        do_reset();
        issue(3'd1, 16'hFFFF); issue(3'd1, 16'd1); issue(3'd6, 16'd0);
        issue(3'd1, 16'd3); issue(3'd1, 16'd5); issue(3'd7, 16'd0); issue(3'd0, 16'd0);

        // Reset lands in the FILL cycle of a refilling SUB.
        do_reset();
        for (int i = 0; i < 4; i++) issue(3'd1, 16'(i + 20));
        issue(3'd7, 16'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        clear_model();
        check_reset_state("reset_in_fill");

        for (int i = 0; i < 1500; i++) begin
            rop  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rop = 3'd1;
            rdat = 16'($urandom);
            if ($urandom_range(0, 9) == 0) rdat = 16'hFFFF;
            issue(rop, rdat);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        issue(3'd0, 16'd0);
        @(posedge clock); #1;
        chk("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
